// File: rtl/cpu_term_gen.sv
// cpu_term_gen: slave-side 68030 bus-cycle terminator for the SDMAC register
// window and the SCSI controller window.
// Ports: CLK, RST (async, active-high), CPU strobes AS_/DS_/R_W, decode hits
//        SEL_REG/SEL_SCSI, SCSI_RDY; registered outputs DSACK_/STERM_/BERR_,
//        their pad enable TERM_OE, and one-cycle RD_STB/WR_STB strobes.
module cpu_term_gen #(
    parameter int unsigned WAIT_REG  = 2,
    parameter int unsigned TIMEOUT   = 200,
    parameter bit          USE_STERM = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS_,
    input  logic       DS_,
    input  logic       R_W,
    input  logic       SEL_REG,
    input  logic       SEL_SCSI,
    input  logic       SCSI_RDY,
    output logic [1:0] DSACK_,
    output logic       STERM_,
    output logic       BERR_,
    output logic       TERM_OE,
    output logic       RD_STB,
    output logic       WR_STB
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD,
        S_ERR,
        S_RECOVER
    } state_e;

    localparam logic [7:0] WAIT_LD = 8'(WAIT_REG);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       scsi_q, scsi_d;
    logic       rw_q, rw_d;
    // Pending flag: SCSI ready seen (WAIT) or AS_ negation seen (HOLD/ERR).
    // Both events take effect one edge after they are sampled.
    logic       pend_q, pend_d;
    logic [1:0] dsack_q, dsack_d;
    logic       sterm_q, sterm_d;
    logic       berr_q, berr_d;
    logic       oe_q, oe_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       go_ack;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scsi_d  = scsi_q;
        rw_d    = rw_q;
        pend_d  = pend_q;
        dsack_d = dsack_q;
        sterm_d = 1'b1;
        berr_d  = berr_q;
        oe_d    = oe_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        go_ack  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!AS_ && (SEL_REG || SEL_SCSI)) begin
                    state_d = S_WAIT;
                    // A double decode hit is served as a register access.
                    scsi_d  = !SEL_REG;
                    rw_d    = R_W;
                    cnt_d   = SEL_REG ? WAIT_LD : 8'd0;
                    pend_d  = 1'b0;
                    oe_d    = 1'b1;
                    rd_d    = R_W;
                end
            end
            S_WAIT: begin
                if (AS_) begin
                    state_d = S_RECOVER;
                end else if (!scsi_q) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        go_ack = 1'b1;
                    end
                end else if (pend_q) begin
                    go_ack = 1'b1;
                end else if (SCSI_RDY) begin
                    // Ready wins over a timeout on the same edge.
                    pend_d = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                    berr_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK: begin
                state_d = S_HOLD;
            end
            S_HOLD, S_ERR: begin
                if (pend_q) begin
                    state_d = S_RECOVER;
                    pend_d  = 1'b0;
                    dsack_d = 2'b11;
                    berr_d  = 1'b1;
                end else if (AS_) begin
                    pend_d = 1'b1;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
                dsack_d = 2'b11;
                berr_d  = 1'b1;
                oe_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_ack) begin
            state_d = S_ACK;
            pend_d  = 1'b0;
            // The SCSI side always answers as a 32-bit DSACK port.
            if (USE_STERM && !scsi_q) begin
                sterm_d = 1'b0;
            end else begin
                dsack_d = 2'b00;
            end
            wr_d = !rw_q && !DS_;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            scsi_q  <= 1'b0;
            rw_q    <= 1'b0;
            pend_q  <= 1'b0;
            dsack_q <= 2'b11;
            sterm_q <= 1'b1;
            berr_q  <= 1'b1;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scsi_q  <= scsi_d;
            rw_q    <= rw_d;
            pend_q  <= pend_d;
            dsack_q <= dsack_d;
            sterm_q <= sterm_d;
            berr_q  <= berr_d;
            oe_q    <= oe_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign DSACK_  = dsack_q;
    assign STERM_  = sterm_q;
    assign BERR_   = berr_q;
    assign TERM_OE = oe_q;
    assign RD_STB  = rd_q;
    assign WR_STB  = wr_q;

endmodule

// File: tb/tb_cpu_term_gen.sv
// tb_cpu_term_gen: bench for cpu_term_gen, three parameterisations driven by
// shared stimulus and checked against a per-transaction timing model.
module tb_cpu_term_gen;

    localparam int NDUT = 3;
    localparam int TO   = 8;
    localparam int WRP [NDUT] = '{2, 0, 5};
    localparam int STP [NDUT] = '{0, 1, 0};
    localparam logic [6:0] IDLE_V = 7'b1111000;

    typedef struct {
        bit scsi;
        bit both;
        bit rw;
        bit dsl;
        int r;
        int l;
    } txn_t;

    typedef struct {
        int on;
        int off;
        int cnt;
        int oe_off;
        int rd;
        int wr;
        int kind;
    } obs_t;

    typedef struct {
        int   d;
        txn_t t;
        obs_t x;
    } vec_t;

    logic       CLK;
    logic       RST;
    logic       AS_;
    logic       DS_;
    logic       R_W;
    logic       SEL_REG;
    logic       SEL_SCSI;
    logic       SCSI_RDY;
    logic [1:0] dsack [NDUT];
    logic       sterm [NDUT];
    logic       berr  [NDUT];
    logic       oe    [NDUT];
    logic       rd    [NDUT];
    logic       wr    [NDUT];

    int   checks;
    int   errs;
    obs_t obs [NDUT];
    vec_t tbl [9];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cpu_term_gen #(
            .WAIT_REG (WRP[g]),
            .TIMEOUT  (TO),
            .USE_STERM(STP[g] != 0)
        ) u_dut (
            .CLK     (CLK),
            .RST     (RST),
            .AS_     (AS_),
            .DS_     (DS_),
            .R_W     (R_W),
            .SEL_REG (SEL_REG),
            .SEL_SCSI(SEL_SCSI),
            .SCSI_RDY(SCSI_RDY),
            .DSACK_  (dsack[g]),
            .STERM_  (sterm[g]),
            .BERR_   (berr[g]),
            .TERM_OE (oe[g]),
            .RD_STB  (rd[g]),
            .WR_STB  (wr[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge 0 is the first edge sampling AS_ low. Derive the edge at which
    // the cycle is terminated (e), whether it errors or aborts, the edge
    // at which AS_ negation is acted on (k) and the edge IDLE is re-entered.
    function automatic void timing(int d, txn_t t, output int e,
                                   output bit err, output bit ab,
                                   output int k, output int fin);
        err = 1'b0;
        if (!t.scsi) begin
            e = 1 + WRP[d];
        end else if (t.r >= 1 && t.r <= TO) begin
            e = t.r + 1;
        end else begin
            e   = TO;
            err = 1'b1;
        end
        ab = (t.l <= e);
        k  = err ? e + 1 : e + 2;
        if (t.l > k) k = t.l;
        fin = ab ? t.l + 1 : k + 2;
    endfunction

    function automatic logic [6:0] expect_out(int d, txn_t t, int j);
        int e, k, fin;
        bit err, ab, tr, st;
        logic [1:0] ds;
        logic sm, be, o, r, w;
        timing(d, t, e, err, ab, k, fin);
        tr = !ab && !err;
        st = (STP[d] != 0) && !t.scsi;
        ds = (tr && !st && j >= e && j <= k) ? 2'b00 : 2'b11;
        sm = !(tr && st && j == e);
        be = !(!ab && err && j >= e && j <= k);
        o  = (j < fin);
        r  = (j == 0) && t.rw;
        w  = tr && !t.rw && t.dsl && (j == e);
        return {ds, sm, be, o, r, w};
    endfunction

    function automatic logic [6:0] sample(int d);
        return {dsack[d], sterm[d], berr[d], oe[d], rd[d], wr[d]};
    endfunction

    function automatic vec_t mkv(int d, bit scsi, bit both, bit rw, bit dsl,
                                 int r, int l, int on, int off, int cnt,
                                 int oeo, int rdc, int wrc, int kind);
        vec_t v;
        v.d        = d;
        v.t.scsi   = scsi;
        v.t.both   = both;
        v.t.rw     = rw;
        v.t.dsl    = dsl;
        v.t.r      = r;
        v.t.l      = l;
        v.x.on     = on;
        v.x.off    = off;
        v.x.cnt    = cnt;
        v.x.oe_off = oeo;
        v.x.rd     = rdc;
        v.x.wr     = wrc;
        v.x.kind   = kind;
        return v;
    endfunction

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_v(string nm, logic [6:0] got, logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic drive(txn_t t, int j);
        if (j < t.l) begin
            AS_      = 1'b0;
            SEL_REG  = !t.scsi;
            SEL_SCSI = t.scsi || t.both;
            R_W      = t.rw;
            DS_      = !t.dsl;
        end else begin
            AS_      = 1'b1;
            SEL_REG  = 1'($urandom_range(0, 1));
            SEL_SCSI = 1'($urandom_range(0, 1));
            R_W      = 1'($urandom_range(0, 1));
            DS_      = 1'($urandom_range(0, 1));
        end
        SCSI_RDY = (t.r != 0) && (j >= t.r);
    endtask

    task automatic idle_in();
        AS_      = 1'b1;
        DS_      = 1'b1;
        R_W      = 1'b1;
        SEL_REG  = 1'b0;
        SEL_SCSI = 1'b0;
        SCSI_RDY = 1'b0;
    endtask

    // Called on a falling edge with every DUT idle; leaves on a falling edge.
    task automatic run_txn(txn_t t, int id);
        int span;
        int e, k, fin;
        bit err, ab;
        logic [6:0] g;
        span = 0;
        for (int d = 0; d < NDUT; d++) begin
            timing(d, t, e, err, ab, k, fin);
            if (fin > span) span = fin;
            obs[d] = '{-1, -1, 0, -1, 0, 0, 0};
        end
        for (int j = 0; j <= span; j++) begin
            drive(t, j);
            @(posedge CLK);
            @(negedge CLK);
            for (int d = 0; d < NDUT; d++) begin
                g = sample(d);
                chk_v($sformatf("t%0d d%0d j%0d", id, d, j), g,
                      expect_out(d, t, j));
                if (g[6:5] == 2'b00 || !g[4] || !g[3]) begin
                    if (obs[d].on < 0) begin
                        obs[d].on   = j;
                        obs[d].kind = (g[6:5] == 2'b00) ? 1 : (!g[4] ? 2 : 3);
                    end
                    obs[d].cnt++;
                end else if (obs[d].on >= 0 && obs[d].off < 0) begin
                    obs[d].off = j;
                end
                if (!g[2] && j > 0 && obs[d].oe_off < 0) obs[d].oe_off = j;
                obs[d].rd += int'(g[1]);
                obs[d].wr += int'(g[0]);
            end
        end
        idle_in();
    endtask

    initial begin
        txn_t t;
        int   d;
        checks = 0;
        errs   = 0;
        idle_in();
        RST = 1'b1;

        // d, scsi, both, rw, dsl, r, l, on, off, cnt, oe_off, rd, wr, kind
        tbl[0] = mkv(0, 0, 0, 1, 1, 0, 6,  3,  7, 4,  8, 1, 0, 1);
        tbl[1] = mkv(1, 0, 0, 0, 1, 0, 6,  1,  2, 1,  8, 0, 1, 2);
        tbl[2] = mkv(0, 1, 0, 1, 1, 5, 10, 6, 11, 5, 12, 1, 0, 1);
        tbl[3] = mkv(0, 1, 0, 0, 1, 0, 12, 8, 13, 5, 14, 0, 0, 3);
        tbl[4] = mkv(2, 0, 0, 1, 1, 0, 3, -1, -1, 0,  4, 1, 0, 0);
        tbl[5] = mkv(1, 1, 0, 1, 1, 1, 4,  2,  5, 3,  6, 1, 0, 1);
        tbl[6] = mkv(0, 0, 0, 0, 0, 0, 5,  3,  6, 3,  7, 0, 0, 1);
        tbl[7] = mkv(0, 1, 0, 1, 1, 8, 12, 9, 13, 4, 14, 1, 0, 1);
        tbl[8] = mkv(0, 0, 1, 0, 1, 0, 4,  3,  6, 3,  7, 0, 1, 1);

        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk_v($sformatf("reset d%0d", i), sample(i), IDLE_V);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].t, i);
            d = tbl[i].d;
            chk($sformatf("v%0d on", i),   obs[d].on,     tbl[i].x.on);
            chk($sformatf("v%0d off", i),  obs[d].off,    tbl[i].x.off);
            chk($sformatf("v%0d cnt", i),  obs[d].cnt,    tbl[i].x.cnt);
            chk($sformatf("v%0d oe", i),   obs[d].oe_off, tbl[i].x.oe_off);
            chk($sformatf("v%0d rd", i),   obs[d].rd,     tbl[i].x.rd);
            chk($sformatf("v%0d wr", i),   obs[d].wr,     tbl[i].x.wr);
            chk($sformatf("v%0d kind", i), obs[d].kind,   tbl[i].x.kind);
        end

        // Reset asserted between clock edges while DUT 0 holds DSACK_ low.
        AS_     = 1'b0;
        SEL_REG = 1'b1;
        R_W     = 1'b1;
        DS_     = 1'b0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("hold dsack", int'(dsack[0]), 0);
        #2 RST = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk_v($sformatf("async rst d%0d", i), sample(i), IDLE_V);
        end
        idle_in();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        run_txn(tbl[0].t, 100);
        chk("post rst on", obs[0].on, 3);

        for (int i = 0; i < 40; i++) begin
            t.scsi = 1'($urandom_range(0, 1));
            t.both = 1'($urandom_range(0, 1));
            t.rw   = 1'($urandom_range(0, 1));
            t.dsl  = ($urandom_range(0, 3) != 0);
            t.r    = int'($urandom_range(0, 11));
            t.l    = int'($urandom_range(1, 14));
            run_txn(t, 200 + i);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
